// File: rtl/mult_share_if.sv
// Request/response bundle between client engines and the shared-multiplier arbiter.
interface mult_share_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [8*NREQ-1:0] req_a;
  logic [8*NREQ-1:0] req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [15:0]       rsp_data;
  logic [IDW-1:0]    rsp_id;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id
  );
endinterface

// File: rtl/mult_share_arbiter.sv
// Round-robin sharing of one external 8x8 combinational multiplier among NREQ clients.
// Define MULT_SHARE_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module mult_share_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic        clk,
  input  logic        rst,
  mult_share_if.slave bus,
  output logic [7:0]  mul_a,
  output logic [7:0]  mul_b,
  input  logic [15:0] mul_p,
  output logic        busy
);

  generate
    if (NREQ < 2 || NREQ > 16) begin : g_bad_nreq
      $error("mult_share_arbiter: NREQ must be in 2..16");
    end
    if (IDW != $clog2(NREQ)) begin : g_bad_idw
      $error("mult_share_arbiter: IDW must equal clog2(NREQ)");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, RESP = 2'd2} state_t;

  state_t         state_reg, state_next;
  logic [IDW-1:0] id_reg;
  logic           rsp_valid_reg;
  logic [15:0]    rsp_data_reg;
  logic [IDW-1:0] rsp_id_reg;
  logic           window;
  logic           found;
  logic           accept;
  logic [IDW-1:0] winner;
  logic [IDW-1:0] cand;

`ifdef MULT_SHARE_FIXED_PRIO_EN
  // Descending scan so the lowest valid index is the last (winning) assignment.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = IDW'(k);
      if (bus.req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end
`else
  logic [IDW-1:0] ptr_reg;

  // Scan from ptr+NREQ down to ptr+1 so the first valid after ptr wins.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = IDW'((int'(ptr_reg) + k) % NREQ);
      if (bus.req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_reg <= IDW'(NREQ - 1);
    end else if (accept) begin
      ptr_reg <= winner;
    end
  end
`endif

  assign window = (state_reg == IDLE) || (state_reg == RESP && bus.rsp_ready);
  assign accept = window && found;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_grant
      assign bus.req_ready[gi] = !rst && accept && (winner == IDW'(gi));
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = MUL;
      MUL:     state_next = RESP;
      RESP:    if (bus.rsp_ready) state_next = accept ? MUL : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_a         <= '0;
      mul_b         <= '0;
      id_reg        <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_data_reg  <= '0;
      rsp_id_reg    <= '0;
    end else begin
      if (accept) begin
        mul_a  <= bus.req_a[8*winner +: 8];
        mul_b  <= bus.req_b[8*winner +: 8];
        id_reg <= winner;
      end
      if (state_reg == MUL) begin
        rsp_data_reg  <= mul_p;
        rsp_id_reg    <= id_reg;
        rsp_valid_reg <= 1'b1;
      end else if (state_reg == RESP && bus.rsp_ready) begin
        rsp_valid_reg <= 1'b0;
      end
    end
  end

  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_data  = rsp_data_reg;
  assign bus.rsp_id    = rsp_id_reg;
  assign busy          = (state_reg != IDLE);

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter: stimulus pushes expected responses, a monitor pops and compares.
module tb_mult_share_arbiter;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  mul_a, mul_b;
  logic [15:0] mul_p;
  logic        busy;

  mult_share_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  mult_share_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .mul_a (mul_a),
    .mul_b (mul_b),
    .mul_p (mul_p),
    .busy  (busy)
  );

  // Environment model of the single combinational multiplier.
  assign mul_p = {8'd0, mul_a} * {8'd0, mul_b};

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [17:0] exp_q[$];
  logic [17:0] mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b);
    bus.req_a[8*i +: 8] = a;
    bus.req_b[8*i +: 8] = b;
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b1;
    cyc();
    cyc();
    chk("rst_req_ready", 32'(bus.req_ready), 0);
    rst = 1'b0;
    #1;
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_mul_a", 32'(mul_a), 0);
    chk("rst_rsp_data", 32'(bus.rsp_data), 0);
    chk("rst_rsp_id", 32'(bus.rsp_id), 0);
  endtask

  task automatic drain();
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    for (int n = 0; n < 20 && (exp_q.size() != 0 || busy); n++) cyc();
    chk("drain_queue_empty", 32'(exp_q.size()), 0);
    chk("drain_idle", 32'(busy), 0);
  endtask

  // Scoreboard monitor: compare on every response handshake.
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got id=%0d data=%0d, required no response", bus.rsp_id, bus.rsp_data);
      end else begin
        mon_e = exp_q.pop_front();
        $display("rsp id=%0d data=%0d (expected id=%0d data=%0d)", bus.rsp_id, bus.rsp_data, mon_e[17:16], mon_e[15:0]);
        chk("rsp_data", 32'(bus.rsp_data), 32'(mon_e[15:0]));
        chk("rsp_id", 32'(bus.rsp_id), 32'(mon_e[17:16]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, required finish before 200000");
    $fatal(1, "timeout");
  end

  int order2[5] = '{0, 1, 2, 3, 0};
  int prod2[4]  = '{2, 6, 12, 20};
  int order5[4];
  int prod5[4]  = '{0, 6, 0, 20};

  initial begin
`ifdef MULT_SHARE_FIXED_PRIO_EN
    order5 = '{1, 1, 1, 1};
`else
    order5 = '{1, 3, 1, 3};
`endif

    // 1: single request, latency and busy
    do_reset();
    set_req(0, 8'd3, 8'd5);
    bus.req_valid = 4'b0001;
    #1;
    chk("t1_grant", 32'(bus.req_ready), 32'b0001);
    exp_q.push_back({2'd0, 16'd15});
    cyc();
    bus.req_valid = '0;
    chk("t1_k1_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("t1_k1_busy", 32'(busy), 1);
    chk("t1_mul_a", 32'(mul_a), 3);
    chk("t1_mul_b", 32'(mul_b), 5);
    cyc();
    chk("t1_k2_rsp_valid", 32'(bus.rsp_valid), 1);
    cyc();
    chk("t1_k3_busy", 32'(busy), 0);
    drain();

    // 2: four requesters continuously valid
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 8'(i + 1), 8'(i + 2));
    bus.req_valid = 4'b1111;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (i % 2 == 0) begin
        chk($sformatf("t2_grant%0d", i / 2), 32'(bus.req_ready), 32'(1 << order2[i / 2]));
        exp_q.push_back({2'(order2[i / 2]), 16'(prod2[order2[i / 2]])});
      end else begin
        chk($sformatf("t2_nogrant%0d", i), 32'(bus.req_ready), 0);
      end
      cyc();
    end
    drain();

    // 3: backpressure after 255*255
    do_reset();
    set_req(0, 8'd255, 8'd255);
    set_req(1, 8'd7, 8'd9);
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b0001;
    #1;
    chk("t3_grant0", 32'(bus.req_ready), 32'b0001);
    exp_q.push_back({2'd0, 16'd65025});
    cyc();
    bus.req_valid = 4'b0010;
    cyc();
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold_valid", 32'(bus.rsp_valid), 1);
      chk("t3_hold_data", 32'(bus.rsp_data), 65025);
      chk("t3_hold_ready", 32'(bus.req_ready), 0);
      cyc();
    end
    bus.rsp_ready = 1'b1;
    #1;
    chk("t3_grant1_same_cycle", 32'(bus.req_ready), 32'b0010);
    exp_q.push_back({2'd1, 16'd63});
    cyc();
    drain();

    // 4: reset in the MUL cycle
    do_reset();
    set_req(0, 8'd10, 8'd10);
    bus.req_valid = 4'b0001;
    cyc();
    bus.req_valid = 4'b0101;
    chk("t4_in_mul", 32'(busy), 1);
    rst = 1'b1;
    #1;
    chk("t4_rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("t4_rst_busy", 32'(busy), 0);
    chk("t4_rst_req_ready", 32'(bus.req_ready), 0);
    cyc();
    cyc();
    set_req(0, 8'd4, 8'd6);
    set_req(2, 8'd1, 8'd1);
    rst = 1'b0;
    #1;
    chk("t4_first_grant_req0", 32'(bus.req_ready), 32'b0001);
    exp_q.push_back({2'd0, 16'd24});
    cyc();
    bus.req_valid = '0;
    drain();

    // 5: requesters 1 and 3 held valid
    do_reset();
    set_req(1, 8'd2, 8'd3);
    set_req(3, 8'd4, 8'd5);
    bus.req_valid = 4'b1010;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (i % 2 == 0) begin
        chk($sformatf("t5_grant%0d", i / 2), 32'(bus.req_ready), 32'(1 << order5[i / 2]));
        exp_q.push_back({2'(order5[i / 2]), 16'(prod5[order5[i / 2]])});
      end
      cyc();
    end
    drain();

    // 6: zero operand
    do_reset();
    set_req(2, 8'd0, 8'd200);
    bus.req_valid = 4'b0100;
    #1;
    chk("t6_grant", 32'(bus.req_ready), 32'b0100);
    exp_q.push_back({2'd2, 16'd0});
    cyc();
    bus.req_valid = '0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mult_share_arbiter.md
Name: mult_share_arbiter

Overview:
Shares one combinational 8x8 unsigned array multiplier between NREQ requesters. Round-robin arbitration selects one request at a time and latches its operands. The block drives the multiplier and registers the 16-bit product. It returns the product with the requester index over a valid/ready response channel. One operation is in flight at a time. The block sits between client engines and a single multiplier instance, so only one multiplier is built.

Parameters:
NREQ, 4, number of requesters; legal range 2..16.
IDW, 2, width of rsp_id; must equal ceil(log2(NREQ)); an elaboration-time check enforces this.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  reset, asynchronous, active-high.
req_valid  input  NREQ  per-requester request valid.
req_ready  output  NREQ  one-hot grant/accept, combinational.
req_a  input  8*NREQ  operand A; requester i uses bits [8i+7:8i].
req_b  input  8*NREQ  operand B, packed the same way.
mul_a  output  8  operand to the multiplier, registered.
mul_b  output  8  operand to the multiplier, registered.
mul_p  input  16  product from the combinational multiplier.
rsp_valid  output  1  response valid.
rsp_ready  input  1  response consumer ready.
rsp_data  output  16  registered product.
rsp_id  output  IDW  index of the requester that issued the operation.
busy  output  1  high in MUL or RESP.

Behaviour:
- Reset (async, active-high):
  - state=IDLE.
  - mul_a=0, mul_b=0.
  - rsp_valid=0, rsp_data=0, rsp_id=0.
  - busy=0.
  - rr pointer=NREQ-1, so requester 0 has first priority.
  - req_ready=0 while rst is high.
- States: IDLE, MUL, RESP (2-bit encoding).
- Arbitration window: the state is IDLE, or the state is RESP and rsp_ready=1 in the same cycle.
  - Winner = first i with req_valid[i]=1, scanning from ptr+1 upward and wrapping modulo NREQ.
  - req_ready[winner]=1; all other req_ready bits are 0.
  - Outside the window, req_ready=0.
- Accept edge (window open and any req_valid):
  - mul_a <= winner's A; mul_b <= winner's B.
  - id register <= winner; ptr <= winner.
  - Next state = MUL.
- MUL (exactly 1 cycle): at the edge, rsp_data <= mul_p, rsp_id <= id, rsp_valid <= 1, state <= RESP.
- RESP:
  - rsp_valid, rsp_data and rsp_id are held stable until rsp_ready=1.
  - On rsp_ready=1 with a request pending: a new accept occurs in the same cycle. Next state=MUL, rsp_valid <= 0.
  - On rsp_ready=1 with no request pending: next state=IDLE, rsp_valid <= 0.
- Latency: accept at cycle k, so rsp_valid=1 in cycle k+2.
- Peak throughput: 1 operation per 2 cycles with rsp_ready tied high.
- Operands and products are unsigned. No truncation is allowed: 255*255 must return 65025.
- mul_a and mul_b keep their last value when not in MUL. This avoids needless toggling.
- A requester dropping req_valid without a grant is legal. It is not tracked.
- req_valid rising while the block is busy waits for the next arbitration window. No request is lost as long as the requester holds req_valid.
- Reset asserted mid-MUL or mid-RESP aborts the operation. No response is produced. All registers return to their reset values immediately.
- An unused requester (req_valid stuck at 0) never receives a grant.

Optional Feature:
Macro: MULT_SHARE_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins. The ptr register is not built and the scan always starts at index 0. All other timing is unchanged.
- Undefined: round-robin as described in Behaviour.

Test Plan:
1. Single request: req_valid=0001, A=3, B=5, rsp_ready=1. Expect req_ready=0001 at cycle k; rsp_valid=1 at k+2 with rsp_data=15, rsp_id=0; busy low at k+3.
2. All four requesters valid continuously with distinct operands (i+1)*(i+2), rsp_ready=1. Expect grants in order 0,1,2,3,0; products 2,6,12,20; one response every 2 cycles.
3. Backpressure: hold rsp_ready=0 for 5 cycles after a 255*255 operation. Expect rsp_valid and rsp_data=65025 stable for all 5 cycles; req_ready=0 throughout; a second request is accepted the same cycle rsp_ready rises.
4. Reset mid-operation: assert rst in the MUL cycle. Expect rsp_valid=0, busy=0, req_ready=0 immediately, with no response after release. The next request from requester 0 is granted first.
5. Macro defined, requesters 1 and 3 held valid. Expect requester 1 granted every time and requester 3 never granted. Without the macro, grants alternate 1,3,1,3.
6. Zero operands: A=0, B=200 from requester 2. Expect rsp_data=0 and rsp_id=2.
